// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter: round-robin arbiter that shares one mist_io SD block port
// among NREQ sector requesters (floppy/HDD controllers).
//
// The winner's LBA, drive slot and direction are latched at grant time and held
// for the whole operation. The sd_ack handshake is tracked: an optional ack
// timeout is applied while waiting for sd_ack to rise. Bytes written into the
// FPGA buffer are counted so that a short read can be detected.
//
// Ports
//   clk_sys, reset_n            clock, asynchronous active-low reset
//   req_rd/req_wr [NREQ]        level requests: read / write one sector
//   req_drive [NREQ]            mist_io drive slot per requester
//   req_lba [NREQ*32]           per-requester LBA, slice i = [32*i +: 32]
//   req_buff_din [NREQ*8]       per-requester buffer read data, slice i = [8*i +: 8]
//   gnt [NREQ]                  one-hot grant, held for the whole operation
//   done/err [NREQ]             one-cycle completion / failure pulses
//   req_buff_wr [NREQ]          sd_buff_wr steered to the granted requester
//   req_buff_addr/req_buff_dout buffer address / data passthrough
//   sd_lba, sd_rd, sd_wr        registered command to mist_io
//   sd_ack, sd_buff_wr,
//   sd_buff_addr, sd_buff_dout  from mist_io
//   sd_buff_din                 granted requester's buffer data, 0 when idle
module sd_block_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter logic [23:0] ACK_TIMEOUT = 24'd0
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_rd,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ-1:0]   req_drive,
  input  logic [NREQ*32-1:0] req_lba,
  input  logic [NREQ*8-1:0] req_buff_din,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic [NREQ-1:0]   req_buff_wr,
  output logic [8:0]        req_buff_addr,
  output logic [7:0]        req_buff_dout,
  output logic [31:0]       sd_lba,
  output logic [1:0]        sd_rd,
  output logic [1:0]        sd_wr,
  input  logic              sd_ack,
  input  logic              sd_buff_wr,
  input  logic [8:0]        sd_buff_addr,
  input  logic [7:0]        sd_buff_dout,
  output logic [7:0]        sd_buff_din
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StXfer,
    StDone,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [1:0]        sd_rd_q, sd_rd_d;
  logic [1:0]        sd_wr_q, sd_wr_d;
  logic [31:0]       sd_lba_q, sd_lba_d;
  logic              drive_q, drive_d;
  logic              is_wr_q, is_wr_d;
  logic [9:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       tmo_cnt_q, tmo_cnt_d;

  // Round-robin winner search starting at rr_ptr.
  logic              pend_any;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   cand_idx;
  logic [IdxW-1:0]   win_next;

  always_comb begin
    pend_any = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand_idx = IdxW'((32'(rr_ptr_q) + k) % NREQ);
      if (!pend_any && (req_rd[cand_idx] || req_wr[cand_idx])) begin
        pend_any = 1'b1;
        win_idx  = cand_idx;
      end
    end
    win_next = IdxW'((32'(win_idx) + 32'd1) % NREQ);
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    err_d      = '0;
    sd_rd_d    = sd_rd_q;
    sd_wr_d    = sd_wr_q;
    sd_lba_d   = sd_lba_q;
    drive_d    = drive_q;
    is_wr_d    = is_wr_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (pend_any) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          idx_d          = win_idx;
          sd_lba_d       = req_lba[win_idx*32 +: 32];
          drive_d        = req_drive[win_idx];
          // A write wins when both request lines are raised together.
          is_wr_d        = req_wr[win_idx];
          if (req_wr[win_idx]) begin
            sd_wr_d = req_drive[win_idx] ? 2'b10 : 2'b01;
            sd_rd_d = 2'b00;
          end else begin
            sd_rd_d = req_drive[win_idx] ? 2'b10 : 2'b01;
            sd_wr_d = 2'b00;
          end
          rr_ptr_d   = win_next;
          tmo_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = StIssue;
        end
      end

      StIssue: begin
        if (sd_ack) begin
          sd_rd_d = 2'b00;
          sd_wr_d = 2'b00;
          state_d = StXfer;
        end else if ((ACK_TIMEOUT != 24'd0) && (tmo_cnt_q == ACK_TIMEOUT - 24'd1)) begin
          sd_rd_d = 2'b00;
          sd_wr_d = 2'b00;
          err_d   = gnt_q;
          state_d = StError;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 24'd1;
        end
      end

      StXfer: begin
        if (sd_buff_wr && (byte_cnt_q != 10'd1023)) begin
          byte_cnt_d = byte_cnt_q + 10'd1;
        end
        if (!sd_ack) begin
          // Writes complete on ack fall; reads must have filled the full sector.
          if (is_wr_q || (byte_cnt_q == 10'd512)) begin
            done_d  = gnt_q;
            state_d = StDone;
          end else begin
            err_d   = gnt_q;
            state_d = StError;
          end
        end
      end

      StDone, StError: begin
        gnt_d   = '0;
        state_d = StIdle;
      end

      default: begin
        gnt_d   = '0;
        sd_rd_d = 2'b00;
        sd_wr_d = 2'b00;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      sd_rd_q    <= 2'b00;
      sd_wr_q    <= 2'b00;
      sd_lba_q   <= '0;
      drive_q    <= 1'b0;
      is_wr_q    <= 1'b0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      sd_rd_q    <= sd_rd_d;
      sd_wr_q    <= sd_wr_d;
      sd_lba_q   <= sd_lba_d;
      drive_q    <= drive_d;
      is_wr_q    <= is_wr_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  always_comb begin
    gnt           = gnt_q;
    done          = done_q;
    err           = err_q;
    sd_rd         = sd_rd_q;
    sd_wr         = sd_wr_q;
    sd_lba        = sd_lba_q;
    req_buff_addr = sd_buff_addr;
    req_buff_dout = sd_buff_dout;
    // Buffer writes from mist_io only reach a requester during the data phase.
    req_buff_wr   = (state_q == StXfer && sd_buff_wr) ? gnt_q : '0;
    sd_buff_din   = (gnt_q != '0) ? req_buff_din[idx_q*8 +: 8] : 8'h00;
  end

endmodule
